debounce_edge: RTL and testbench
================================

DEBOUNCE_EDGE -- requirements
Module: debounce_edge

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, number of consecutive equal samples required to accept a new level (legal range 2..65535).
REQ-002 SHALL have parameter CNT_W, default 16, width of the internal stability counter (2^CNT_W > STABLE_CYCLES).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port D  input  1  raw level from the upstream negedge D flip-flop Q output.
REQ-006 SHALL have port en  input  1  sample enable; 0 freezes all state.
REQ-007 SHALL have port clr  input  1  synchronous clear of edge_cnt only.
REQ-008 SHALL have port Q  output  1  debounced level.
REQ-009 SHALL have port Qbar  output  1  always ~Q.
REQ-010 SHALL have port rise  output  1  one-cycle pulse on accepted 0->1.
REQ-011 SHALL have port fall  output  1  one-cycle pulse on accepted 1->0.
REQ-012 SHALL have port edge_cnt  output  8  count of accepted rising transitions.

Function
REQ-013 SHALL implement FSM states IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW.
REQ-014 IDLE_LOW: D=1 sampled -> WAIT_HIGH, cnt=1; else stay, cnt=0.
REQ-015 WAIT_HIGH: D=0 -> IDLE_LOW, cnt=0; D=1 and cnt==STABLE_CYCLES-1 -> IDLE_HIGH, Q=1, rise=1; else cnt+1.
REQ-016 IDLE_HIGH: D=0 sampled -> WAIT_LOW, cnt=1; else stay, cnt=0.
REQ-017 WAIT_LOW: D=1 -> IDLE_HIGH, cnt=0; D=0 and cnt==STABLE_CYCLES-1 -> IDLE_LOW, Q=0, fall=1; else cnt+1.
REQ-018 Latency: Q changes on the STABLE_CYCLES-th consecutive sampling edge of the new level; a glitch shorter than STABLE_CYCLES samples SHALL leave Q, rise, fall unchanged.
REQ-019 rise and fall SHALL be registered, high exactly one cycle, never simultaneously.
REQ-020 Q SHALL change only in WAIT_HIGH->IDLE_HIGH or WAIT_LOW->IDLE_LOW transitions.
REQ-021 en=0: state, cnt, Q, edge_cnt held; rise and fall driven 0 that cycle.
REQ-022 edge_cnt SHALL increment on each cycle rise is asserted, wrapping 255->0.
REQ-023 clr=1 SHALL set edge_cnt to 0 next cycle; clr and a rise in the same cycle SHALL yield edge_cnt=1.
REQ-024 clr SHALL act regardless of en.
REQ-025 cnt SHALL never exceed STABLE_CYCLES-1 (no wrap).

Reset
REQ-026 rst=1 at posedge clk SHALL force state=IDLE_LOW, cnt=0, Q=0, Qbar=1, rise=0, fall=0, edge_cnt=0.
REQ-027 rst SHALL take priority over en and clr; reset mid-WAIT_HIGH discards the partial count and emits no rise.
REQ-028 After reset release, first sample SHALL be taken on the next posedge clk.

Structure
REQ-029 State encodings (2-bit) and the EDGE_CNT_W=8 constant SHALL live in shared package debounce_pkg.
REQ-030 Stability counter (load 1 / clear / increment / terminal compare) SHALL be sub-module stable_counter, parameterised by CNT_W and STABLE_CYCLES.
REQ-031 FSM, output registers and edge_cnt SHALL remain in debounce_edge.

Verification
REQ-032 rst=1 two cycles, D=1 -> Q=0, Qbar=1, rise=0, fall=0, edge_cnt=0.
REQ-033 STABLE_CYCLES=4, en=1, D 0->1 held 6 cycles -> Q=1 after 4th sampling edge, rise one cycle, edge_cnt=1.
REQ-034 D high 3 samples then low (glitch) -> Q stays 0, no rise, FSM back in IDLE_LOW.
REQ-035 Q=1 state, D low 4 samples -> fall one cycle, Q=0, edge_cnt unchanged.
REQ-036 D high 2 samples, en=0 for 5 cycles, en=1, D high 2 more samples -> Q=1 on 4th enabled sample.
REQ-037 256 accepted rises -> edge_cnt wraps to 0; clr coincident with rise -> edge_cnt=1.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared constants for the debounce_edge slice: FSM state encodings,
// the edge counter width, and the stability counter operation codes.
package debounce_pkg;

    // Width of the accepted-rising-edge counter.
    localparam int EDGE_CNT_W = 8;

    // FSM state encodings (2-bit).
    localparam logic [1:0] IDLE_LOW  = 2'd0;
    localparam logic [1:0] WAIT_HIGH = 2'd1;
    localparam logic [1:0] IDLE_HIGH = 2'd2;
    localparam logic [1:0] WAIT_LOW  = 2'd3;

    // Operation requested of the stability counter in a given cycle.
    typedef enum logic [1:0] {
        CNT_HOLD  = 2'd0,
        CNT_CLEAR = 2'd1,
        CNT_LOAD1 = 2'd2,
        CNT_INC   = 2'd3
    } cnt_op_t;

    // Next value of the edge counter: a clear wins, but a rise in the same
    // cycle still gets counted so that edge is never lost.
    function automatic logic [EDGE_CNT_W-1:0] edge_cnt_update(
        input logic [EDGE_CNT_W-1:0] cur,
        input logic                  clr,
        input logic                  rise
    );
        logic [EDGE_CNT_W-1:0] res;
        if (clr) begin
            res = rise ? EDGE_CNT_W'(1) : '0;
        end else if (rise) begin
            res = cur + 1'b1;
        end else begin
            res = cur;
        end
        return res;
    endfunction

endpackage

// File: rtl/stable_counter.sv
// Stability counter: counts consecutive samples of a candidate level.
// Supports clear, load-with-1 and saturating increment; flags when the
// count has reached the acceptance threshold (STABLE_CYCLES-1).
module stable_counter
    import debounce_pkg::*;
#(
    parameter int CNT_W         = 16,
    parameter int STABLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  cnt_op_t          op,
    output logic [CNT_W-1:0] cnt,
    output logic             terminal
);

    localparam logic [CNT_W-1:0] TERMINAL_VAL = CNT_W'(STABLE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_reg;

    // Counter register: frozen when sampling is disabled; the increment
    // saturates at the terminal value so it can never wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (en) begin
            case (op)
                CNT_CLEAR: cnt_reg <= '0;
                CNT_LOAD1: cnt_reg <= CNT_W'(1);
                CNT_INC:   if (cnt_reg != TERMINAL_VAL) cnt_reg <= cnt_reg + 1'b1;
                default:   cnt_reg <= cnt_reg;
            endcase
        end
    end

    assign cnt      = cnt_reg;
    assign terminal = (cnt_reg == TERMINAL_VAL);

endmodule

// File: rtl/debounce_edge.sv
// Debouncer with edge detection: accepts a new level of D only after
// STABLE_CYCLES consecutive equal samples, emits one-cycle rise/fall
// pulses on accepted transitions and counts accepted rising edges.
module debounce_edge
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  D,
    input  logic                  en,
    input  logic                  clr,
    output logic                  Q,
    output logic                  Qbar,
    output logic                  rise,
    output logic                  fall,
    output logic [EDGE_CNT_W-1:0] edge_cnt
);

    logic [1:0]            state_reg, state_next;
    logic                  q_reg, q_next;
    logic                  rise_reg, rise_next;
    logic                  fall_reg, fall_next;
    logic [EDGE_CNT_W-1:0] edge_cnt_reg, edge_cnt_next;

    cnt_op_t               cnt_op;
    logic                  cnt_terminal;
    logic [CNT_W-1:0]      cnt_value;

    stable_counter #(
        .CNT_W         (CNT_W),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_stable_counter (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .op       (cnt_op),
        .cnt      (cnt_value),
        .terminal (cnt_terminal)
    );

    // FSM next-state and counter control; with en low everything holds
    // and no pulse is generated.
    always_comb begin
        state_next = state_reg;
        q_next     = q_reg;
        rise_next  = 1'b0;
        fall_next  = 1'b0;
        cnt_op     = CNT_HOLD;
        if (en) begin
            case (state_reg)
                IDLE_LOW: begin
                    if (D) begin
                        state_next = WAIT_HIGH;
                        cnt_op     = CNT_LOAD1;
                    end else begin
                        cnt_op = CNT_CLEAR;
                    end
                end
                WAIT_HIGH: begin
                    if (!D) begin
                        state_next = IDLE_LOW;
                        cnt_op     = CNT_CLEAR;
                    end else if (cnt_terminal) begin
                        state_next = IDLE_HIGH;
                        q_next     = 1'b1;
                        rise_next  = 1'b1;
                        cnt_op     = CNT_CLEAR;
                    end else begin
                        cnt_op = CNT_INC;
                    end
                end
                IDLE_HIGH: begin
                    if (!D) begin
                        state_next = WAIT_LOW;
                        cnt_op     = CNT_LOAD1;
                    end else begin
                        cnt_op = CNT_CLEAR;
                    end
                end
                default: begin // WAIT_LOW
                    if (D) begin
                        state_next = IDLE_HIGH;
                        cnt_op     = CNT_CLEAR;
                    end else if (cnt_terminal) begin
                        state_next = IDLE_LOW;
                        q_next     = 1'b0;
                        fall_next  = 1'b1;
                        cnt_op     = CNT_CLEAR;
                    end else begin
                        cnt_op = CNT_INC;
                    end
                end
            endcase
        end
    end

    // Edge counter next value; clr works even while sampling is disabled.
    always_comb begin
        edge_cnt_next = edge_cnt_update(edge_cnt_reg, clr, rise_next);
    end

    // State and output registers; reset overrides enable and clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE_LOW;
            q_reg        <= 1'b0;
            rise_reg     <= 1'b0;
            fall_reg     <= 1'b0;
            edge_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            q_reg        <= q_next;
            rise_reg     <= rise_next;
            fall_reg     <= fall_next;
            edge_cnt_reg <= edge_cnt_next;
        end
    end

    assign Q        = q_reg;
    assign Qbar     = ~q_reg;
    assign rise     = rise_reg;
    assign fall     = fall_reg;
    assign edge_cnt = edge_cnt_reg;

    // The raw count is only needed by the terminal compare inside the
    // counter; keep it observable without driving any output.
    logic cnt_unused;
    assign cnt_unused = ^cnt_value;

endmodule

// File: tb/tb_debounce_edge.sv
// Directed testbench for debounce_edge with STABLE_CYCLES=4.
module tb_debounce_edge;

    logic       clk = 1'b0;
    logic       rst, D, en, clr;
    logic       Q, Qbar, rise, fall;
    logic [7:0] edge_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    debounce_edge #(
        .STABLE_CYCLES (4),
        .CNT_W         (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .D        (D),
        .en       (en),
        .clr      (clr),
        .Q        (Q),
        .Qbar     (Qbar),
        .rise     (rise),
        .fall     (fall),
        .edge_cnt (edge_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: value=%0h", tag, got);
        end
    endtask

    // Advance one clock and sample just after the active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold D at lvl for n sampling edges.
    task automatic hold_level(input logic lvl, input int n);
        for (int i = 0; i < n; i++) begin
            D = lvl;
            step();
        end
    endtask

    initial begin
        rst = 1'b1; D = 1'b1; en = 1'b1; clr = 1'b0;

        // Reset with D high for two cycles.
        step(); step();
        check_eq("rst_Q", Q, 0);
        check_eq("rst_Qbar", Qbar, 1);
        check_eq("rst_rise", rise, 0);
        check_eq("rst_fall", fall, 0);
        check_eq("rst_edge_cnt", edge_cnt, 0);
        rst = 1'b0;
        hold_level(1'b0, 2);

        // Clean rise: Q goes high on the 4th sampling edge.
        hold_level(1'b1, 3);
        check_eq("rise_q_before_4th", Q, 0);
        check_eq("rise_pulse_before_4th", rise, 0);
        hold_level(1'b1, 1);
        check_eq("rise_q_at_4th", Q, 1);
        check_eq("rise_qbar_at_4th", Qbar, 0);
        check_eq("rise_pulse", rise, 1);
        check_eq("rise_edge_cnt", edge_cnt, 1);
        hold_level(1'b1, 1);
        check_eq("rise_pulse_one_cycle", rise, 0);
        hold_level(1'b1, 1);
        check_eq("rise_q_held", Q, 1);

        // Fall: 4 low samples from Q=1.
        hold_level(1'b0, 3);
        check_eq("fall_q_before_4th", Q, 1);
        hold_level(1'b0, 1);
        check_eq("fall_q_at_4th", Q, 0);
        check_eq("fall_pulse", fall, 1);
        check_eq("fall_rise_quiet", rise, 0);
        check_eq("fall_edge_cnt_same", edge_cnt, 1);
        hold_level(1'b0, 1);
        check_eq("fall_pulse_one_cycle", fall, 0);

        // Glitch: 3 high samples then low; count must restart from zero.
        hold_level(1'b1, 3);
        hold_level(1'b0, 1);
        check_eq("glitch_q", Q, 0);
        check_eq("glitch_rise", rise, 0);
        hold_level(1'b1, 3);
        check_eq("glitch_restart_q", Q, 0);
        check_eq("glitch_restart_rise", rise, 0);
        hold_level(1'b1, 1);
        check_eq("glitch_then_accept_q", Q, 1);
        check_eq("glitch_then_accept_cnt", edge_cnt, 2);
        hold_level(1'b0, 4);
        check_eq("back_low_q", Q, 0);

        // Enable freeze: 2 samples, 5 frozen cycles, then 2 more samples.
        hold_level(1'b1, 2);
        en = 1'b0;
        hold_level(1'b1, 5);
        check_eq("freeze_q", Q, 0);
        check_eq("freeze_rise", rise, 0);
        en = 1'b1;
        hold_level(1'b1, 1);
        check_eq("freeze_3rd_q", Q, 0);
        hold_level(1'b1, 1);
        check_eq("freeze_4th_q", Q, 1);
        check_eq("freeze_4th_rise", rise, 1);
        check_eq("freeze_edge_cnt", edge_cnt, 3);
        hold_level(1'b0, 4);

        // Clear works while disabled.
        en = 1'b0; clr = 1'b1;
        step();
        check_eq("clr_while_disabled", edge_cnt, 0);
        clr = 1'b0; en = 1'b1;

        // Reset mid WAIT_HIGH discards the partial count.
        hold_level(1'b1, 2);
        rst = 1'b1;
        step();
        check_eq("midrst_q", Q, 0);
        check_eq("midrst_rise", rise, 0);
        rst = 1'b0;
        hold_level(1'b1, 3);
        check_eq("midrst_restart_q", Q, 0);
        hold_level(1'b1, 1);
        check_eq("midrst_accept_q", Q, 1);
        check_eq("midrst_edge_cnt", edge_cnt, 1);
        hold_level(1'b0, 4);

        // Wrap: 254 more rises reach 255, the 256th wraps to 0.
        for (int r = 0; r < 254; r++) begin
            hold_level(1'b1, 4);
            hold_level(1'b0, 4);
        end
        check_eq("wrap_at_255", edge_cnt, 255);
        hold_level(1'b1, 4);
        check_eq("wrap_rise", rise, 1);
        check_eq("wrap_to_0", edge_cnt, 0);
        hold_level(1'b0, 4);

        // Clear coincident with an accepted rise leaves edge_cnt=1.
        hold_level(1'b1, 3);
        clr = 1'b1;
        hold_level(1'b1, 1);
        clr = 1'b0;
        check_eq("clr_rise_pulse", rise, 1);
        check_eq("clr_rise_edge_cnt", edge_cnt, 1);
        hold_level(1'b1, 2);
        check_eq("clr_rise_edge_cnt_held", edge_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // rise and fall must never be asserted together.
    always @(negedge clk) begin
        if (rise && fall) begin
            check_eq("rise_fall_exclusive", {rise, fall}, 2'b00);
        end
    end

endmodule
